// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared defaults and FSM encoding for the SRAM read arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default SRAM address / data widths
//   WAIT_CYCLES_DEF         : default SRAM read wait cycles
//   arb_state_e             : IDLE / WAIT state encoding
package cpu_pkg;
  localparam int ADDR_W_DEF      = 18;
  localparam int DATA_W_DEF      = 16;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int NUM_REQ         = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick -- two-requester winner selection.
//   valid_i[1:0] : asserted requests
//   last_i       : index granted last; on a tie the other requester wins
//   grant_o[1:0] : one-hot winner, 2'b00 when nothing is requested
module sram_arb_pick (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end
endmodule

// File: rtl/sram_read_arbiter.sv
// sram_read_arbiter -- arbitrates two read requesters onto one asynchronous
// SRAM. One read occupies WAIT_CYCLES+1 cycles from accept to response.
//   CLK, RST              : clock, synchronous active-high reset
//   REQ_VALID/REQ_READY   : per-requester handshake (READY combinational)
//   REQ_ADDR0/REQ_ADDR1   : per-requester read address
//   RSP_VALID/RSP_DATA    : one-cycle response pulse + shared captured word
//   SRAM_A/SRAM_D         : registered address out, read data in
//   SRAM_WE..SRAM_UB      : fixed read-only strobes
//   BUSY                  : high while a read is in flight
// Build option: SRAM_ARB_RR_EN selects round-robin arbitration; when it is
// undefined requester 0 wins every tie and no pointer register exists.
module sram_read_arbiter
  import cpu_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        REQ_VALID,
  input  logic [ADDR_W-1:0] REQ_ADDR0,
  input  logic [ADDR_W-1:0] REQ_ADDR1,
  output logic [1:0]        REQ_READY,
  output logic [1:0]        RSP_VALID,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic [ADDR_W-1:0] SRAM_A,
  input  logic [DATA_W-1:0] SRAM_D,
  output logic              SRAM_WE,
  output logic              SRAM_CE,
  output logic              SRAM_OE,
  output logic              SRAM_LB,
  output logic              SRAM_UB,
  output logic              BUSY
);
  arb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        rsp_q, rsp_d;
  logic [1:0]        grant;
  logic              last_grant;

`ifdef SRAM_ARB_RR_EN
  // Index granted last; reset to 1 so requester 0 is favoured first.
  logic last_q;
  always_ff @(posedge CLK) begin
    if (RST)                                 last_q <= 1'b1;
    else if (state_q == IDLE && (|grant))    last_q <= grant[1];
  end
  assign last_grant = last_q;
`else
  // Tie always resolves to requester 0.
  assign last_grant = 1'b1;
`endif

  sram_arb_pick u_pick (
    .valid_i (REQ_VALID),
    .last_i  (last_grant),
    .grant_o (grant)
  );

  // Grant is already gated by REQ_VALID, so READY never rises on an idle bit.
  assign REQ_READY = (state_q == IDLE) ? grant : 2'b00;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rsp_d   = 2'b00;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          gnt_d   = grant[1];
          addr_d  = grant[1] ? REQ_ADDR1 : REQ_ADDR0;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          data_d  = SRAM_D;
          rsp_d   = gnt_q ? 2'b10 : 2'b01;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rsp_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
    end
  end

  assign SRAM_A    = addr_q;
  assign RSP_DATA  = data_q;
  assign RSP_VALID = rsp_q;
  assign BUSY      = (state_q != IDLE);

  assign SRAM_WE = 1'b1;
  assign SRAM_CE = 1'b0;
  assign SRAM_OE = 1'b0;
  assign SRAM_LB = 1'b0;
  assign SRAM_UB = 1'b0;
endmodule

// File: tb/tb_sram_read_arbiter.sv
// tb_sram_read_arbiter -- directed bench for sram_read_arbiter. Three
// instances share stimulus: WAIT_CYCLES = 2 (main), 1 and 15.
module tb_sram_read_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [1:0]    REQ_VALID = 2'b00;
  logic [AW-1:0] A0 = '0, A1 = '0;
  logic [DW-1:0] SRAM_D = '0;

  logic [1:0] rdy, rv, rdy1, rv1, rdy15, rv15;
  logic [DW-1:0] rd, rd1, rd15;
  logic [AW-1:0] sa, sa1, sa15;
  logic we, ce, oe, lb, ub, busy;
  logic we1, ce1, oe1, lb1, ub1, busy1;
  logic we15, ce15, oe15, lb15, ub15, busy15;

  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  sram_read_arbiter #(.WAIT_CYCLES(2), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_ADDR0(A0), .REQ_ADDR1(A1),
    .REQ_READY(rdy), .RSP_VALID(rv), .RSP_DATA(rd), .SRAM_A(sa), .SRAM_D(SRAM_D),
    .SRAM_WE(we), .SRAM_CE(ce), .SRAM_OE(oe), .SRAM_LB(lb), .SRAM_UB(ub), .BUSY(busy));

  sram_read_arbiter #(.WAIT_CYCLES(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_ADDR0(A0), .REQ_ADDR1(A1),
    .REQ_READY(rdy1), .RSP_VALID(rv1), .RSP_DATA(rd1), .SRAM_A(sa1), .SRAM_D(SRAM_D),
    .SRAM_WE(we1), .SRAM_CE(ce1), .SRAM_OE(oe1), .SRAM_LB(lb1), .SRAM_UB(ub1), .BUSY(busy1));

  sram_read_arbiter #(.WAIT_CYCLES(15), .ADDR_W(AW), .DATA_W(DW)) dut15 (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_ADDR0(A0), .REQ_ADDR1(A1),
    .REQ_READY(rdy15), .RSP_VALID(rv15), .RSP_DATA(rd15), .SRAM_A(sa15), .SRAM_D(SRAM_D),
    .SRAM_WE(we15), .SRAM_CE(ce15), .SRAM_OE(oe15), .SRAM_LB(lb15), .SRAM_UB(ub15), .BUSY(busy15));

  // Advance into the next cycle; inputs are driven 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ_VALID = 2'b00;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ_VALID = 2'b00;
    tick(); tick(); tick();
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    nvec++; if (sa !== '0) begin nerr++; $display("FAIL reset_sram_a: got %h want 0", sa); end
    nvec++; if (rd !== '0) begin nerr++; $display("FAIL reset_rsp_data: got %h want 0", rd); end
    nvec++; if (rv !== 2'b00) begin nerr++; $display("FAIL reset_rsp_valid: got %b want 00", rv); end
    nvec++; if (rdy !== 2'b00) begin nerr++; $display("FAIL reset_ready: got %b want 00", rdy); end
    nvec++; if ({we, ce, oe, lb, ub} !== 5'b10000) begin
      nerr++; $display("FAIL reset_strobes: got %b want 10000", {we, ce, oe, lb, ub});
    end
    RST = 1'b0;
  endtask

  // Combinational probes only; REQ_VALID drops again before the edge.
  task automatic test_single_pick();
    REQ_VALID = 2'b10; #1;
    nvec++; if (rdy !== 2'b10) begin nerr++; $display("FAIL pick_only1: got %b want 10", rdy); end
    REQ_VALID = 2'b11; #1;
    nvec++; if (rdy !== 2'b01) begin nerr++; $display("FAIL pick_tie_after_reset: got %b want 01", rdy); end
    REQ_VALID = 2'b00; #1;
    nvec++; if (rdy !== 2'b00) begin nerr++; $display("FAIL pick_none: got %b want 00", rdy); end
  endtask

  task automatic test_single_read();
    do_reset();
    REQ_VALID = 2'b01; A0 = 18'h00010; SRAM_D = 16'hBEEF; #1;
    nvec++; if (rdy !== 2'b01) begin nerr++; $display("FAIL sr_ready_T0: got %b want 01", rdy); end
    tick(); REQ_VALID = 2'b00; #1;
    nvec++; if (sa !== 18'h00010) begin nerr++; $display("FAIL sr_sram_a_T1: got %h want 00010", sa); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL sr_busy_T1: got %b want 1", busy); end
    tick();
    nvec++; if (rv !== 2'b00) begin nerr++; $display("FAIL sr_rsp_T2: got %b want 00", rv); end
    tick();
    nvec++; if (rv !== 2'b01) begin nerr++; $display("FAIL sr_rsp_T3: got %b want 01", rv); end
    nvec++; if (rd !== 16'hBEEF) begin nerr++; $display("FAIL sr_data_T3: got %h want beef", rd); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL sr_busy_T3: got %b want 0", busy); end
    SRAM_D = 16'h0000;
    tick();
    nvec++; if (rv !== 2'b00) begin nerr++; $display("FAIL sr_rsp_T4: got %b want 00", rv); end
    nvec++; if (rd !== 16'hBEEF) begin nerr++; $display("FAIL sr_data_hold: got %h want beef", rd); end
    nvec++; if (sa !== 18'h00010) begin nerr++; $display("FAIL sr_addr_hold: got %h want 00010", sa); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp, prev;
    do_reset();
    REQ_VALID = 2'b11; A0 = 18'h00100; A1 = 18'h00200;
    prev = 2'b00;
    for (int k = 0; k < 4; k++) begin
      exp = (RR && (k % 2 == 1)) ? 2'b10 : 2'b01;
      #1;
      nvec++; if (rdy !== exp) begin nerr++; $display("FAIL b2b_ready k=%0d: got %b want %b", k, rdy, exp); end
      if (k > 0) begin
        nvec++; if (rv !== prev) begin nerr++; $display("FAIL b2b_rsp k=%0d: got %b want %b", k, rv, prev); end
        nvec++; if (rd !== 16'(16'h1000 + k - 1)) begin
          nerr++; $display("FAIL b2b_data k=%0d: got %h want %h", k, rd, 16'(16'h1000 + k - 1));
        end
      end
      tick(); SRAM_D = 16'(16'h1000 + k); #1;
      nvec++; if (sa !== (exp[1] ? 18'h00200 : 18'h00100)) begin
        nerr++; $display("FAIL b2b_addr k=%0d: got %h want %h", k, sa, exp[1] ? 18'h00200 : 18'h00100);
      end
      nvec++; if (rdy !== 2'b00) begin nerr++; $display("FAIL b2b_ready_wait k=%0d: got %b want 00", k, rdy); end
      tick(); tick();
      prev = exp;
    end
    REQ_VALID = 2'b00; #1;
    nvec++; if (rv !== prev) begin nerr++; $display("FAIL b2b_rsp_last: got %b want %b", rv, prev); end
  endtask

  task automatic test_arrive_in_wait();
    do_reset();
    REQ_VALID = 2'b01; A0 = 18'h00033; A1 = 18'h00044; SRAM_D = 16'h5A5A; #1;
    nvec++; if (rdy !== 2'b01) begin nerr++; $display("FAIL aw_ready_T0: got %b want 01", rdy); end
    tick(); REQ_VALID = 2'b10; #1;
    nvec++; if (rdy !== 2'b00) begin nerr++; $display("FAIL aw_ready_T1: got %b want 00", rdy); end
    tick(); #1;
    nvec++; if (rdy !== 2'b00) begin nerr++; $display("FAIL aw_ready_T2: got %b want 00", rdy); end
    tick(); #1;
    nvec++; if (rdy !== 2'b10) begin nerr++; $display("FAIL aw_ready_T3: got %b want 10", rdy); end
    nvec++; if (rv !== 2'b01) begin nerr++; $display("FAIL aw_rsp_T3: got %b want 01", rv); end
    tick(); REQ_VALID = 2'b00; #1;
    nvec++; if (sa !== 18'h00044) begin nerr++; $display("FAIL aw_addr_T4: got %h want 00044", sa); end
    tick(); tick();
    nvec++; if (rv !== 2'b10) begin nerr++; $display("FAIL aw_rsp_T6: got %b want 10", rv); end
  endtask

  task automatic test_reset_in_wait();
    int seen;
    do_reset();
    REQ_VALID = 2'b01; A0 = 18'h00055; #1;
    nvec++; if (rdy !== 2'b01) begin nerr++; $display("FAIL rw_ready_T0: got %b want 01", rdy); end
    tick(); REQ_VALID = 2'b00; RST = 1'b1;
    tick(); RST = 1'b0; #1;
    nvec++; if (sa !== '0) begin nerr++; $display("FAIL rw_sram_a_T2: got %h want 0", sa); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rw_busy_T2: got %b want 0", busy); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rv !== 2'b00) seen++;
      tick();
    end
    nvec++; if (seen !== 0) begin nerr++; $display("FAIL rw_no_rsp: got %0d pulses want 0", seen); end
  endtask

  task automatic test_wait_cycles();
    int f1, f2, f15;
    do_reset();
    REQ_VALID = 2'b01; A0 = 18'h00077; SRAM_D = 16'h1234;
    f1 = 0; f2 = 0; f15 = 0;
    for (int t = 1; t <= 20; t++) begin
      tick(); REQ_VALID = 2'b00; #1;
      if (f1 == 0 && rv1[0] === 1'b1) f1 = t;
      if (f2 == 0 && rv[0] === 1'b1) f2 = t;
      if (f15 == 0 && rv15[0] === 1'b1) f15 = t;
    end
    nvec++; if (f1 !== 2) begin nerr++; $display("FAIL wc1_latency: got T%0d want T2", f1); end
    nvec++; if (f2 !== 3) begin nerr++; $display("FAIL wc2_latency: got T%0d want T3", f2); end
    nvec++; if (f15 !== 16) begin nerr++; $display("FAIL wc15_latency: got T%0d want T16", f15); end
    nvec++; if (rd15 !== 16'h1234) begin nerr++; $display("FAIL wc15_data: got %h want 1234", rd15); end
  endtask

  initial begin
    test_reset();
    test_single_pick();
    test_single_read();
    test_back_to_back();
    test_arrive_in_wait();
    test_reset_in_wait();
    test_wait_cycles();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
